// File: rtl/sfp_link_ctrl.sv
// ---------------------------------------------------------------------------
// sfp_link_ctrl
// SFP+ port supervisor sitting directly upstream of the 10G MAC. It
// synchronises and debounces the SFP status pins, drives TXDISABLE/RATESEL,
// sequences the MAC reset once the reference clock is programmed and a
// module is present, and retries a bounded number of times on TX fault
// before locking out.
//
// Optional feature macro: SFP_LOS_RESET_EN
//   defined   : a debounced LOS rising edge in RUN re-enters ENABLE, which
//               re-pulses mac_rst_n low for RST_HOLD_CYCLES (txfault wins
//               if both are seen on the same cycle).
//   undefined : LOS only gates link_up.
//
// Ports
//   clk           in   50 MHz board clock
//   rst_n         in   asynchronous active-low reset
//   init_done     in   Si570 init complete (synchronous level)
//   sfp_prsnt_n   in   module present pin, async, low = present
//   sfp_los       in   loss-of-signal pin, async, high = LOS
//   sfp_txfault   in   TX fault pin, async, high = fault
//   sfp_txdisable out  laser disable, high = off
//   sfp_ratesel   out  constant RATESEL
//   mac_rst_n     out  MAC reset, active low
//   link_up       out  RUN and debounced LOS low
//   fault         out  high in LOCKOUT
//   retry_cnt     out  fault episodes since last IDLE
//   state         out  FSM encoding for debug/CSR
// ---------------------------------------------------------------------------
module sfp_link_ctrl #(
    parameter int         DEBOUNCE_CYCLES = 50000,
    parameter int         RST_HOLD_CYCLES = 10,
    parameter int         RETRY_CYCLES    = 5000000,
    parameter int         MAX_RETRIES     = 3,
    parameter logic [1:0] RATESEL         = 2'b11,
    parameter int         CNT_W           = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init_done,
    input  logic       sfp_prsnt_n,
    input  logic       sfp_los,
    input  logic       sfp_txfault,
    output logic       sfp_txdisable,
    output logic [1:0] sfp_ratesel,
    output logic       mac_rst_n,
    output logic       link_up,
    output logic       fault,
    output logic [2:0] retry_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENABLE  = 3'd1,
        ST_RUN     = 3'd2,
        ST_FAULT   = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_e;

    // Pin vector order: [0] prsnt_n, [1] los, [2] txfault.
    // Idle values: not present, LOS asserted, no fault.
    localparam logic [2:0]       PIN_RST    = 3'b011;
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RETRY_LAST = CNT_W'(RETRY_CYCLES - 1);
    localparam logic [3:0]       MAX_R      = 4'(MAX_RETRIES);

    logic [2:0]            sync1_r;
    logic [2:0]            sync2_r;
    logic [2:0]            db_r;
    logic [2:0][CNT_W-1:0] db_cnt_r;

    state_e                state_r;
    state_e                state_nxt_s;
    logic [CNT_W-1:0]      timer_r;
    logic [2:0]            retry_r;
    logic [2:0]            retry_nxt_s;
    logic                  txdis_r;
    logic                  mac_rst_n_r;
    logic                  link_up_r;
    logic                  fault_r;

    logic                  present_s;
    logic                  los_s;
    logic                  txfault_s;

    assign present_s = ~db_r[0];
    assign los_s     = db_r[1];
    assign txfault_s = db_r[2];

`ifdef SFP_LOS_RESET_EN
    logic los_d_r;
    logic los_rise_s;

    assign los_rise_s = los_s & ~los_d_r;

    // Previous debounced LOS, for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            los_d_r <= 1'b1;
        end else begin
            los_d_r <= los_s;
        end
    end
`endif

    // Two-flop synchroniser for the asynchronous SFP pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= PIN_RST;
            sync2_r <= PIN_RST;
        end else begin
            sync1_r <= {sfp_txfault, sfp_los, sfp_prsnt_n};
            sync2_r <= sync1_r;
        end
    end

    // Per-pin debounce: accept a new level after DEBOUNCE_CYCLES differing samples in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_r     <= PIN_RST;
            db_cnt_r <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] == db_r[i]) begin
                    db_cnt_r[i] <= '0;
                end else if (db_cnt_r[i] == DB_LAST) begin
                    db_r[i]     <= sync2_r[i];
                    db_cnt_r[i] <= '0;
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + CNT_ONE;
                end
            end
        end
    end

    // Next-state and retry-count decode; removal beats init loss beats fault.
    always_comb begin
        state_nxt_s = state_r;
        retry_nxt_s = retry_r;
        if (state_r == ST_IDLE) begin
            retry_nxt_s = 3'd0;
            if (init_done && present_s) begin
                state_nxt_s = ST_ENABLE;
            end else begin
                state_nxt_s = ST_IDLE;
            end
        end else if (!present_s) begin
            state_nxt_s = ST_IDLE;
            retry_nxt_s = 3'd0;
        end else if (!init_done && (state_r != ST_LOCKOUT)) begin
            // LOCKOUT is sticky until the module is pulled.
            state_nxt_s = ST_IDLE;
            retry_nxt_s = 3'd0;
        end else begin
            case (state_r)
                ST_ENABLE: begin
                    if (timer_r == HOLD_LAST) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_ENABLE;
                    end
                end
                ST_RUN: begin
                    if (txfault_s) begin
                        retry_nxt_s = (retry_r == 3'd7) ? 3'd7 : (retry_r + 3'd1);
                        if (({1'b0, retry_r} + 4'd1) == MAX_R) begin
                            state_nxt_s = ST_LOCKOUT;
                        end else begin
                            state_nxt_s = ST_FAULT;
                        end
`ifdef SFP_LOS_RESET_EN
                    end else if (los_rise_s) begin
                        state_nxt_s = ST_ENABLE;
`endif
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_FAULT: begin
                    if (timer_r == RETRY_LAST) begin
                        state_nxt_s = ST_ENABLE;
                    end else begin
                        state_nxt_s = ST_FAULT;
                    end
                end
                ST_LOCKOUT: begin
                    state_nxt_s = ST_LOCKOUT;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    retry_nxt_s = 3'd0;
                end
            endcase
        end
    end

    // Shared timer: cleared on every state entry, counts only in timed states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_r <= '0;
        end else if (state_nxt_s != state_r) begin
            timer_r <= '0;
        end else if ((state_r == ST_ENABLE) || (state_r == ST_FAULT)) begin
            timer_r <= timer_r + CNT_ONE;
        end else begin
            timer_r <= '0;
        end
    end

    // FSM state and outputs, all decoded from the next state so they move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            retry_r     <= 3'd0;
            txdis_r     <= 1'b1;
            mac_rst_n_r <= 1'b0;
            link_up_r   <= 1'b0;
            fault_r     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            retry_r     <= retry_nxt_s;
            txdis_r     <= ~((state_nxt_s == ST_ENABLE) || (state_nxt_s == ST_RUN));
            mac_rst_n_r <= (state_nxt_s == ST_RUN);
            link_up_r   <= (state_nxt_s == ST_RUN) && !los_s;
            fault_r     <= (state_nxt_s == ST_LOCKOUT);
        end
    end

    assign sfp_txdisable = txdis_r;
    assign sfp_ratesel   = RATESEL;
    assign mac_rst_n     = mac_rst_n_r;
    assign link_up       = link_up_r;
    assign fault         = fault_r;
    assign retry_cnt     = retry_r;
    assign state         = state_r;

endmodule

// File: tb/tb_sfp_link_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sfp_link_ctrl
// Directed bring-up/glitch/fault/lockout/collision/reset scenarios followed
// by a randomized pin-toggling run, all compared every cycle against a
// behavioural model: debounce is a sliding window over pin history, the
// controller is a state plus "cycles spent in state" counter.
// ---------------------------------------------------------------------------
module tb_sfp_link_ctrl;

    localparam int DB    = 4;
    localparam int HOLD  = 3;
    localparam int RETRY = 8;
    localparam int MAXR  = 2;

    localparam int S_IDLE = 0, S_EN = 1, S_RUN = 2, S_FLT = 3, S_LOCK = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       init_done = 1'b1;
    logic       sfp_prsnt_n = 1'b0;
    logic       sfp_los = 1'b0;
    logic       sfp_txfault = 1'b0;
    logic       sfp_txdisable;
    logic [1:0] sfp_ratesel;
    logic       mac_rst_n;
    logic       link_up;
    logic       fault;
    logic [2:0] retry_cnt;
    logic [2:0] state;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #10 clk = ~clk;

    sfp_link_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .RST_HOLD_CYCLES(HOLD),
        .RETRY_CYCLES   (RETRY),
        .MAX_RETRIES    (MAXR),
        .RATESEL        (2'b11),
        .CNT_W          (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .init_done    (init_done),
        .sfp_prsnt_n  (sfp_prsnt_n),
        .sfp_los      (sfp_los),
        .sfp_txfault  (sfp_txfault),
        .sfp_txdisable(sfp_txdisable),
        .sfp_ratesel  (sfp_ratesel),
        .mac_rst_n    (mac_rst_n),
        .link_up      (link_up),
        .fault        (fault),
        .retry_cnt    (retry_cnt),
        .state        (state)
    );

    // ---------------- behavioural model ----------------
    bit m_hist [3][DB+2];   // [pin][age], age 0 = newest sample; pins: prsnt_n, los, txfault
    bit m_db   [3];
    bit m_los_prev;
    int m_st, m_time, m_retry;
    bit e_txdis, e_mac, e_link, e_fault;

    function automatic void model_reset();
        bit rv [3];
        rv = '{1'b1, 1'b1, 1'b0};
        for (int p = 0; p < 3; p++) begin
            m_db[p] = rv[p];
            for (int a = 0; a < DB + 2; a++) m_hist[p][a] = rv[p];
        end
        m_los_prev = 1'b1;
        m_st = S_IDLE; m_time = 0; m_retry = 0;
        e_txdis = 1'b1; e_mac = 1'b0; e_link = 1'b0; e_fault = 1'b0;
    endfunction

    // Advance the model across one rising edge using the currently driven pins.
    function automatic void model_step();
        bit present, los, tf, rise;
        bit pins [3];
        int prev;
        present = !m_db[0]; los = m_db[1]; tf = m_db[2];
        rise = m_db[1] && !m_los_prev;
        m_los_prev = m_db[1];
        prev = m_st;
        if (m_st == S_IDLE) begin
            m_retry = 0;
            if (init_done && present) m_st = S_EN;
        end else if (!present) begin
            m_st = S_IDLE; m_retry = 0;
        end else if (!init_done && m_st != S_LOCK) begin
            m_st = S_IDLE; m_retry = 0;
        end else if (m_st == S_EN) begin
            if (m_time + 1 == HOLD) m_st = S_RUN;
        end else if (m_st == S_FLT) begin
            if (m_time + 1 == RETRY) m_st = S_EN;
        end else if (m_st == S_RUN) begin
            if (tf) begin
                m_st = (m_retry + 1 == MAXR) ? S_LOCK : S_FLT;
                m_retry = (m_retry + 1 > 7) ? 7 : m_retry + 1;
            end
`ifdef SFP_LOS_RESET_EN
            else if (rise) m_st = S_EN;
`endif
        end
        m_time = (m_st == prev) ? m_time + 1 : 0;
        e_txdis = !(m_st == S_EN || m_st == S_RUN);
        e_mac   = (m_st == S_RUN);
        e_fault = (m_st == S_LOCK);
        e_link  = (m_st == S_RUN) && !los;
        // debounce: accept the other level when the DB samples that have
        // crossed the synchroniser all differ from the accepted level
        pins = '{sfp_prsnt_n, sfp_los, sfp_txfault};
        for (int p = 0; p < 3; p++) begin
            bit all_diff;
            for (int a = DB + 1; a > 0; a--) m_hist[p][a] = m_hist[p][a-1];
            m_hist[p][0] = pins[p];
            all_diff = 1'b1;
            for (int a = 2; a < DB + 2; a++) if (m_hist[p][a] == m_db[p]) all_diff = 1'b0;
            if (all_diff) m_db[p] = !m_db[p];
        end
    endfunction

    // ---------------- checking ----------------
    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic check_outputs();
        cmp("txdisable", {7'd0, sfp_txdisable}, {7'd0, e_txdis});
        cmp("mac_rst_n", {7'd0, mac_rst_n}, {7'd0, e_mac});
        cmp("link_up",   {7'd0, link_up}, {7'd0, e_link});
        cmp("fault",     {7'd0, fault}, {7'd0, e_fault});
        cmp("retry_cnt", {5'd0, retry_cnt}, 8'(m_retry));
        cmp("state",     {5'd0, state}, 8'(m_st));
        cmp("ratesel",   {6'd0, sfp_ratesel}, 8'h03);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_literals(input string tag);
        cmp({tag, "_txdis"}, {7'd0, sfp_txdisable}, 8'd1);
        cmp({tag, "_mac"},   {7'd0, mac_rst_n}, 8'd0);
        cmp({tag, "_link"},  {7'd0, link_up}, 8'd0);
        cmp({tag, "_fault"}, {7'd0, fault}, 8'd0);
        cmp({tag, "_retry"}, {5'd0, retry_cnt}, 8'd0);
        cmp({tag, "_state"}, {5'd0, state}, 8'd0);
        cmp({tag, "_rsel"},  {6'd0, sfp_ratesel}, 8'd3);
    endtask

    // Asynchronous reset pulse issued between clock edges.
    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #2;
        check_reset_literals(tag);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        model_reset();
        #35;
        check_reset_literals("por");
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;

        // 1. power-up bring-up with hand-computed edges
        for (int i = 0; i < 12; i++) begin
            tick();
            if (cyc == 6)  cmp("pu_txdis_c6", {7'd0, sfp_txdisable}, 8'd1);
            if (cyc == 7)  cmp("pu_txdis_c7", {7'd0, sfp_txdisable}, 8'd0);
            if (cyc == 7)  cmp("pu_state_c7", {5'd0, state}, 8'd1);
            if (cyc == 9)  cmp("pu_mac_c9",   {7'd0, mac_rst_n}, 8'd0);
            if (cyc == 10) cmp("pu_mac_c10",  {7'd0, mac_rst_n}, 8'd1);
            if (cyc == 10) cmp("pu_link_c10", {7'd0, link_up}, 8'd1);
        end

        // 2. glitches shorter than the debounce window
        sfp_txfault = 1'b1; ticks(3); sfp_txfault = 1'b0; ticks(8);
        cmp("glitch_tf_state", {5'd0, state}, 8'd2);
        sfp_prsnt_n = 1'b1; ticks(3); sfp_prsnt_n = 1'b0; ticks(8);
        cmp("glitch_prs_mac", {7'd0, mac_rst_n}, 8'd1);

        // 3. single fault episode and retry
        sfp_txfault = 1'b1;
        ticks(6);
        cmp("flt_state_6", {5'd0, state}, 8'd2);
        tick();
        cmp("flt_state_7", {5'd0, state}, 8'd3);
        cmp("flt_retry", {5'd0, retry_cnt}, 8'd1);
        cmp("flt_txdis", {7'd0, sfp_txdisable}, 8'd1);
        sfp_txfault = 1'b0;
        ticks(7);
        cmp("flt_hold_14", {5'd0, state}, 8'd3);
        tick();
        cmp("flt_enable_15", {5'd0, state}, 8'd1);
        ticks(3);
        cmp("flt_run_again", {5'd0, state}, 8'd2);

`ifdef SFP_LOS_RESET_EN
        begin
            int low_cnt;
            low_cnt = 0;
            sfp_los = 1'b1;
            for (int i = 0; i < 14; i++) begin
                tick();
                if (mac_rst_n == 1'b0) low_cnt++;
            end
            cmp("los_mac_low_cycles", 8'(low_cnt), 8'd3);
            cmp("los_retry_kept", {5'd0, retry_cnt}, 8'd1);
            sfp_los = 1'b0;
            ticks(8);
        end
`endif

        // 4. second episode locks out; removal clears; reinsertion restarts
        sfp_txfault = 1'b1;
        ticks(7);
        cmp("lock_state", {5'd0, state}, 8'd4);
        cmp("lock_fault", {7'd0, fault}, 8'd1);
        cmp("lock_retry", {5'd0, retry_cnt}, 8'd2);
        sfp_txfault = 1'b0;
        ticks(10);
        cmp("lock_sticky", {5'd0, state}, 8'd4);
        sfp_prsnt_n = 1'b1;
        ticks(7);
        cmp("rm_state", {5'd0, state}, 8'd0);
        cmp("rm_fault", {7'd0, fault}, 8'd0);
        cmp("rm_retry", {5'd0, retry_cnt}, 8'd0);
        sfp_prsnt_n = 1'b0;
        ticks(10);
        cmp("reins_run", {5'd0, state}, 8'd2);

        // 5. collisions
        sfp_prsnt_n = 1'b1; sfp_txfault = 1'b1;
        ticks(7);
        cmp("coll_idle", {5'd0, state}, 8'd0);
        sfp_prsnt_n = 1'b0; sfp_txfault = 1'b0;
        ticks(10);
        cmp("coll_rerun", {5'd0, state}, 8'd2);
        init_done = 1'b0;
        tick();
        cmp("initdrop_state", {5'd0, state}, 8'd0);
        cmp("initdrop_mac", {7'd0, mac_rst_n}, 8'd0);
        init_done = 1'b1;
        ticks(4);
        cmp("initback_run", {5'd0, state}, 8'd2);

        // 6. asynchronous reset in the middle of FAULT
        sfp_txfault = 1'b1;
        ticks(9);
        cmp("pre_rst_fault", {5'd0, state}, 8'd3);
        sfp_txfault = 1'b0;
        #3;
        async_reset("midflt");
        ticks(10);
        cmp("post_rst_run", {5'd0, state}, 8'd2);

        // 7. randomized pin activity
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 4)  sfp_prsnt_n = ~sfp_prsnt_n;
            if ($urandom_range(0, 99) < 6)  sfp_los     = ~sfp_los;
            if ($urandom_range(0, 99) < 6)  sfp_txfault = ~sfp_txfault;
            if ($urandom_range(0, 99) < 2)  init_done   = ~init_done;
            if ($urandom_range(0, 999) < 2) begin
                #3;
                async_reset("rnd");
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
